// File: rtl/pipeline_dout.sv
// rtl/pipeline_dout.sv - enable-gated multi-stage pipeline register for the data-memory read value
module pipeline_dout #(
  parameter int WIDTH = 1,
  parameter int STAGES = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] Dout_in,
  output logic [WIDTH-1:0] Dout_out
);

  if (STAGES < 1 || STAGES > 8 || WIDTH < 1) begin : g_bad_params
    $fatal(1, "pipeline_dout: illegal parameters WIDTH=%0d STAGES=%0d", WIDTH, STAGES);
  end

  logic [WIDTH-1:0] s [STAGES];

  // Whole chain shifts together on enabled edges; a stalled edge leaves every stage untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) s[i] <= RESET_VALUE;
    end else if (en) begin
      s[0] <= Dout_in;
      for (int i = 1; i < STAGES; i++) s[i] <= s[i-1];
    end
  end

  assign Dout_out = s[STAGES-1];

endmodule

// File: tb/tb_pipeline_dout.sv
// tb/tb_pipeline_dout.sv - directed checks for pipeline_dout in three configurations
module tb_pipeline_dout;

  logic clk;
  logic clk_run;

  logic        rst_a, en_a;
  logic [0:0]  din_a, out_a;
  logic        rst_b, en_b;
  logic [31:0] din_b, out_b;
  logic        rst_c, en_c;
  logic [31:0] din_c, out_c;

  int n_checks;
  int n_fail;

  typedef struct {
    logic        en;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  pipeline_dout #(.WIDTH(1), .STAGES(1)) u_a (
    .clk(clk), .reset(rst_a), .en(en_a), .Dout_in(din_a), .Dout_out(out_a)
  );

  pipeline_dout #(.WIDTH(32), .STAGES(3)) u_b (
    .clk(clk), .reset(rst_b), .en(en_b), .Dout_in(din_b), .Dout_out(out_b)
  );

  pipeline_dout #(.WIDTH(32), .STAGES(1), .RESET_VALUE(32'hFFFF0000)) u_c (
    .clk(clk), .reset(rst_c), .en(en_c), .Dout_in(din_c), .Dout_out(out_c)
  );

  initial begin
    clk = 1'b0;
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clk_run  = 1'b0;
    rst_a = 1'b0; en_a = 1'b0; din_a = 1'b0;
    rst_b = 1'b0; en_b = 1'b0; din_b = 32'h0;
    rst_c = 1'b0; en_c = 1'b0; din_c = 32'h0;

    vecs[0]  = '{1'b1, 32'h11111111, 32'h00000000};
    vecs[1]  = '{1'b1, 32'h22222222, 32'h00000000};
    vecs[2]  = '{1'b0, 32'h99999999, 32'h00000000};
    vecs[3]  = '{1'b0, 32'h88888888, 32'h00000000};
    vecs[4]  = '{1'b1, 32'h33333333, 32'h11111111};
    vecs[5]  = '{1'b1, 32'h44444444, 32'h22222222};
    vecs[6]  = '{1'b0, 32'h55555555, 32'h22222222};
    vecs[7]  = '{1'b1, 32'h66666666, 32'h33333333};
    vecs[8]  = '{1'b1, 32'h77777777, 32'h44444444};
    vecs[9]  = '{1'b1, 32'hDEADBEEF, 32'h66666666};
    vecs[10] = '{1'b1, 32'hDEADBEEF, 32'h77777777};
    vecs[11] = '{1'b1, 32'hDEADBEEF, 32'hDEADBEEF};

    // Asynchronous reset with no clock running
    #100;
    din_a = 1'b1; en_a = 1'b1; rst_a = 1'b1;
    din_b = 32'h12345678; en_b = 1'b1; rst_b = 1'b1;
    din_c = 32'h00000001; en_c = 1'b1; rst_c = 1'b1;
    #1;
    check("reset_async_a", {31'h0, out_a}, 32'h0);
    check("reset_async_b", out_b, 32'h0);
    check("reset_async_c", out_c, 32'hFFFF0000);

    clk_run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("reset_hold_a%0d", i), {31'h0, out_a}, 32'h0);
      check($sformatf("reset_hold_b%0d", i), out_b, 32'h0);
      check($sformatf("reset_hold_c%0d", i), out_c, 32'hFFFF0000);
    end

    // WIDTH=1, STAGES=1: capture and stall
    rst_a = 1'b0; en_a = 1'b1; din_a = 1'b1;
    tick();
    check("a_cap1", {31'h0, out_a}, 32'h1);
    din_a = 1'b0;
    tick();
    check("a_cap0", {31'h0, out_a}, 32'h0);
    din_a = 1'b1;
    tick();
    check("a_load1", {31'h0, out_a}, 32'h1);
    en_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      din_a = 1'(i % 2);
      tick();
      check($sformatf("a_stall%0d", i), {31'h0, out_a}, 32'h1);
    end
    en_a = 1'b1; din_a = 1'b0;
    tick();
    check("a_release", {31'h0, out_a}, 32'h0);

    // WIDTH=32, STAGES=3: ordered traffic with stalls, then fill with DEADBEEF
    rst_b = 1'b0;
    for (int i = 0; i < 12; i++) begin
      en_b  = vecs[i].en;
      din_b = vecs[i].din;
      tick();
      check($sformatf("b_vec%0d", i), out_b, vecs[i].exp);
    end

    // Reset pulse between edges discards everything in flight
    #2;
    rst_b = 1'b1;
    #1;
    check("b_midreset", out_b, 32'h0);
    #1;
    rst_b = 1'b0;
    en_b = 1'b1; din_b = 32'hA5A5A5A5;
    tick();
    check("b_after_rst0", out_b, 32'h0);
    tick();
    check("b_after_rst1", out_b, 32'h0);
    tick();
    check("b_after_rst2", out_b, 32'hA5A5A5A5);

    // Non-zero RESET_VALUE
    rst_c = 1'b0; en_c = 1'b1; din_c = 32'h00000001;
    tick();
    check("c_first", out_c, 32'h00000001);
    en_c = 1'b0; din_c = 32'h00000002;
    tick();
    check("c_stall", out_c, 32'h00000001);
    #2;
    rst_c = 1'b1;
    #1;
    check("c_reset_again", out_c, 32'hFFFF0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
